ai_bridge: RTL and testbench

Parametrised Avalon-MM slave between the NIOS II AI software and the game hardware, generalising the single-enemy AI register window to NUM_ENEMIES channels. Captures frame-consistent snapshots of player and enemy locations on the frame sync, and double-buffers per-enemy AI command words so new commands reach the sprite logic only on a frame boundary. Sits in the SoC alongside the VGA/sprite controller, which supplies FRAME_SYNC and locations and consumes ENEMY_CMD.

---
 rtl/ai_bridge_if.sv | 33 +++
 rtl/ai_bridge.sv | 198 +++++++++++++++++++
 tb/tb_ai_bridge.sv | 239 +++++++++++++++++++++++
 3 files changed

// File: rtl/ai_bridge_if.sv
// ============================================================================
//  Module      : ai_bridge_if
//  Description : Avalon-MM slave bus bundle for the AI register window.
//                The master modport drives requests, the slave modport
//                returns read data.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface ai_bridge_if #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 4
);
  logic                  AI_READ;
  logic                  AI_WRITE;
  logic                  AI_CS;
  logic [DATA_W/8-1:0]   AI_BYTE_EN;
  logic [ADDR_W-1:0]     AI_ADDR;
  logic [DATA_W-1:0]     AI_WRITEDATA;
  logic [DATA_W-1:0]     AI_READDATA;

  modport master (
    output AI_READ, AI_WRITE, AI_CS, AI_BYTE_EN, AI_ADDR, AI_WRITEDATA,
    input  AI_READDATA
  );

  modport slave (
    input  AI_READ, AI_WRITE, AI_CS, AI_BYTE_EN, AI_ADDR, AI_WRITEDATA,
    output AI_READDATA
  );
endinterface

`default_nettype wire

// File: rtl/ai_bridge.sv
// ============================================================================
//  Module      : ai_bridge
//  Description : Avalon-MM register window between the AI software and the
//                game hardware. Captures frame-consistent snapshots of player
//                and enemy locations and double-buffers per-enemy command
//                words so they reach the sprite logic on a frame boundary.
//                Optional macro AI_IRQ_EN adds the AI_IRQ level interrupt and
//                the storable CTRL.IRQ_EN bit.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module ai_bridge #(
  parameter int DATA_W      = 16,
  parameter int NUM_ENEMIES = 4,
  parameter int ADDR_W      = 4
) (
  input  wire                           CLK,
  input  wire                           RESET,
  ai_bridge_if.slave                    bus,
  input  wire                           FRAME_SYNC,
  input  wire  [DATA_W-1:0]             PLAYER_LOC,
  input  wire  [NUM_ENEMIES*DATA_W-1:0] ENEMY_LOC,
  output logic [NUM_ENEMIES*DATA_W-1:0] ENEMY_CMD,
  output logic                          CMD_UPDATE
`ifdef AI_IRQ_EN
  ,
  output logic                          AI_IRQ
`endif
);
  localparam int BE_W = DATA_W / 8;
  localparam int ED_W = NUM_ENEMIES * DATA_W;

  typedef enum logic [0:0] {
    ST_IDLE    = 1'b0,
    ST_PENDING = 1'b1
  } state_t;

  state_t            state_q, state_d;
  logic              auto_snap_q, auto_snap_d;
  logic              snap_valid_q, snap_valid_d;
  logic              overrun_q, overrun_d;
  logic [DATA_W-1:0] frame_cnt_q, frame_cnt_d;
  logic [DATA_W-1:0] player_snap_q, player_snap_d;
  logic [ED_W-1:0]   enemy_snap_q, enemy_snap_d;
  logic [ED_W-1:0]   cmd_shadow_q, cmd_shadow_d;
  logic [ED_W-1:0]   enemy_cmd_q, enemy_cmd_d;
  logic              cmd_update_q, cmd_update_d;
  logic [DATA_W-1:0] readdata_q, readdata_d;
`ifdef AI_IRQ_EN
  logic              irq_en_q, irq_en_d;
  logic              irq_q, irq_d;
`endif

  logic              wr_en, rd_en, ctrl_wr, stat_wr;
  logic              snap_wr, commit_wr, clr_valid, clr_ovr;
  logic              snap_evt, do_commit;
  logic [DATA_W-1:0] rd_word;

  // Replace only the byte lanes whose enable is set.
  function automatic logic [DATA_W-1:0] byte_merge(
    input logic [DATA_W-1:0] old_v,
    input logic [DATA_W-1:0] new_v,
    input logic [BE_W-1:0]   be
  );
    byte_merge = old_v;
    for (int b = 0; b < BE_W; b++) begin
      if (be[b]) byte_merge[b*8 +: 8] = new_v[b*8 +: 8];
    end
  endfunction

  // Register-file write decode, snapshot capture and status bookkeeping.
  always_comb begin
    wr_en     = bus.AI_CS && bus.AI_WRITE;
    // All CTRL/STATUS bits live in byte 0, so only that lane matters.
    ctrl_wr   = wr_en && (bus.AI_ADDR == ADDR_W'(0)) && bus.AI_BYTE_EN[0];
    stat_wr   = wr_en && (bus.AI_ADDR == ADDR_W'(1)) && bus.AI_BYTE_EN[0];
    snap_wr   = ctrl_wr && bus.AI_WRITEDATA[0];
    commit_wr = ctrl_wr && bus.AI_WRITEDATA[1];
    clr_valid = stat_wr && bus.AI_WRITEDATA[0];
    clr_ovr   = stat_wr && bus.AI_WRITEDATA[1];

    auto_snap_d = ctrl_wr ? bus.AI_WRITEDATA[2] : auto_snap_q;
`ifdef AI_IRQ_EN
    irq_en_d    = ctrl_wr ? bus.AI_WRITEDATA[3] : irq_en_q;
    irq_d       = irq_en_q && snap_valid_q;
`endif

    // A manual SNAP coinciding with an auto capture is a single event.
    snap_evt      = (FRAME_SYNC && auto_snap_q) || snap_wr;
    player_snap_d = snap_evt ? PLAYER_LOC : player_snap_q;
    enemy_snap_d  = snap_evt ? ENEMY_LOC  : enemy_snap_q;

    // Set beats clear; an overrun needs a still-valid unread snapshot.
    snap_valid_d = snap_evt ? 1'b1 : (clr_valid ? 1'b0 : snap_valid_q);
    if (snap_evt && snap_valid_q && !clr_valid) overrun_d = 1'b1;
    else if (clr_ovr)                           overrun_d = 1'b0;
    else                                        overrun_d = overrun_q;

    frame_cnt_d = FRAME_SYNC ? frame_cnt_q + DATA_W'(1) : frame_cnt_q;

    cmd_shadow_d = cmd_shadow_q;
    for (int i = 0; i < NUM_ENEMIES; i++) begin
      if (wr_en && (bus.AI_ADDR == ADDR_W'(4 + NUM_ENEMIES + i)))
        cmd_shadow_d[i*DATA_W +: DATA_W] =
          byte_merge(cmd_shadow_q[i*DATA_W +: DATA_W], bus.AI_WRITEDATA, bus.AI_BYTE_EN);
    end
  end

  // Commit FSM: arm on COMMIT, transfer shadow to active on the next frame.
  always_comb begin
    state_d   = state_q;
    do_commit = 1'b0;
    case (state_q)
      ST_IDLE:    if (commit_wr) state_d = ST_PENDING;
      ST_PENDING: if (FRAME_SYNC) begin
        state_d   = ST_IDLE;
        do_commit = 1'b1;
      end
      default:    state_d = ST_IDLE;
    endcase
    // Uses the pre-write shadow, so a same-cycle shadow write waits a frame.
    enemy_cmd_d  = do_commit ? cmd_shadow_q : enemy_cmd_q;
    cmd_update_d = do_commit;
  end

  // Read mux from current register values; returns zero when not reading.
  always_comb begin
    rd_en   = bus.AI_CS && bus.AI_READ;
    rd_word = '0;
    if (bus.AI_ADDR == ADDR_W'(0)) begin
      rd_word[2] = auto_snap_q;
`ifdef AI_IRQ_EN
      rd_word[3] = irq_en_q;
`endif
    end else if (bus.AI_ADDR == ADDR_W'(1)) begin
      rd_word[2:0] = {state_q == ST_PENDING, overrun_q, snap_valid_q};
    end else if (bus.AI_ADDR == ADDR_W'(2)) begin
      rd_word = frame_cnt_q;
    end else if (bus.AI_ADDR == ADDR_W'(3)) begin
      rd_word = player_snap_q;
    end
    for (int i = 0; i < NUM_ENEMIES; i++) begin
      if (bus.AI_ADDR == ADDR_W'(4 + i))
        rd_word = enemy_snap_q[i*DATA_W +: DATA_W];
      if (bus.AI_ADDR == ADDR_W'(4 + NUM_ENEMIES + i))
        rd_word = cmd_shadow_q[i*DATA_W +: DATA_W];
    end
    readdata_d = rd_en ? rd_word : '0;
  end

  // State register with synchronous reset.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q       <= ST_IDLE;
      auto_snap_q   <= 1'b0;
      snap_valid_q  <= 1'b0;
      overrun_q     <= 1'b0;
      frame_cnt_q   <= '0;
      player_snap_q <= '0;
      enemy_snap_q  <= '0;
      cmd_shadow_q  <= '0;
      enemy_cmd_q   <= '0;
      cmd_update_q  <= 1'b0;
      readdata_q    <= '0;
`ifdef AI_IRQ_EN
      irq_en_q      <= 1'b0;
      irq_q         <= 1'b0;
`endif
    end else begin
      state_q       <= state_d;
      auto_snap_q   <= auto_snap_d;
      snap_valid_q  <= snap_valid_d;
      overrun_q     <= overrun_d;
      frame_cnt_q   <= frame_cnt_d;
      player_snap_q <= player_snap_d;
      enemy_snap_q  <= enemy_snap_d;
      cmd_shadow_q  <= cmd_shadow_d;
      enemy_cmd_q   <= enemy_cmd_d;
      cmd_update_q  <= cmd_update_d;
      readdata_q    <= readdata_d;
`ifdef AI_IRQ_EN
      irq_en_q      <= irq_en_d;
      irq_q         <= irq_d;
`endif
    end
  end

  assign bus.AI_READDATA = readdata_q;
  assign ENEMY_CMD       = enemy_cmd_q;
  assign CMD_UPDATE      = cmd_update_q;
`ifdef AI_IRQ_EN
  assign AI_IRQ          = irq_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_ai_bridge.sv
// ============================================================================
//  Module      : tb_ai_bridge
//  Description : Directed self-checking bench for ai_bridge. A second,
//                8-bit instance exercises the FRAME_CNT wrap cheaply.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_ai_bridge;
  logic        CLK = 1'b0;
  logic        RESET = 1'b1;
  logic        FRAME_SYNC = 1'b0;
  logic [15:0] PLAYER_LOC = '0;
  logic [63:0] ENEMY_LOC = '0;
  logic [63:0] ENEMY_CMD;
  logic        CMD_UPDATE;
`ifdef AI_IRQ_EN
  logic        AI_IRQ;
  logic        AI_IRQ2;
`endif

  logic        fs2 = 1'b0;
  logic [7:0]  player_loc2 = '0;
  logic [7:0]  enemy_loc2 = '0;
  logic [7:0]  enemy_cmd2;
  logic        cmd_update2;

  int checks = 0;
  int failures = 0;
  int upd_cnt = 0;
  int upd_base;
  logic [15:0] rdv;

  ai_bridge_if #(.DATA_W(16), .ADDR_W(4)) bus ();
  ai_bridge_if #(.DATA_W(8),  .ADDR_W(3)) bus2 ();

  ai_bridge #(.DATA_W(16), .NUM_ENEMIES(4), .ADDR_W(4)) dut (
    .CLK(CLK), .RESET(RESET), .bus(bus), .FRAME_SYNC(FRAME_SYNC),
    .PLAYER_LOC(PLAYER_LOC), .ENEMY_LOC(ENEMY_LOC),
    .ENEMY_CMD(ENEMY_CMD), .CMD_UPDATE(CMD_UPDATE)
`ifdef AI_IRQ_EN
    , .AI_IRQ(AI_IRQ)
`endif
  );

  ai_bridge #(.DATA_W(8), .NUM_ENEMIES(1), .ADDR_W(3)) dut_small (
    .CLK(CLK), .RESET(RESET), .bus(bus2), .FRAME_SYNC(fs2),
    .PLAYER_LOC(player_loc2), .ENEMY_LOC(enemy_loc2),
    .ENEMY_CMD(enemy_cmd2), .CMD_UPDATE(cmd_update2)
`ifdef AI_IRQ_EN
    , .AI_IRQ(AI_IRQ2)
`endif
  );

  always #5 CLK = ~CLK;

  // Count every CMD_UPDATE pulse seen on a clock edge.
  always @(posedge CLK) begin
    if (CMD_UPDATE) upd_cnt <= upd_cnt + 1;
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // All tasks start and end at a falling edge.
  task automatic cycle();
    @(posedge CLK);
    @(negedge CLK);
  endtask

  task automatic wr(input logic [3:0] a, input logic [15:0] d, input logic [1:0] be, input logic fs);
    bus.AI_CS = 1'b1; bus.AI_WRITE = 1'b1; bus.AI_ADDR = a;
    bus.AI_WRITEDATA = d; bus.AI_BYTE_EN = be; FRAME_SYNC = fs;
    cycle();
    bus.AI_CS = 1'b0; bus.AI_WRITE = 1'b0; FRAME_SYNC = 1'b0;
  endtask

  task automatic rd(input logic [3:0] a, output logic [15:0] d);
    bus.AI_CS = 1'b1; bus.AI_READ = 1'b1; bus.AI_ADDR = a;
    cycle();
    d = bus.AI_READDATA;
    bus.AI_CS = 1'b0; bus.AI_READ = 1'b0;
  endtask

  task automatic sync();
    FRAME_SYNC = 1'b1;
    cycle();
    FRAME_SYNC = 1'b0;
  endtask

  initial begin
    bus.AI_CS = 0; bus.AI_READ = 0; bus.AI_WRITE = 0;
    bus.AI_ADDR = '0; bus.AI_WRITEDATA = '0; bus.AI_BYTE_EN = '0;
    bus2.AI_CS = 0; bus2.AI_READ = 0; bus2.AI_WRITE = 0;
    bus2.AI_ADDR = '0; bus2.AI_WRITEDATA = '0; bus2.AI_BYTE_EN = '0;
    @(negedge CLK); cycle();
    RESET = 1'b0;

    // Reset state: every address reads zero.
    for (int a = 0; a < 16; a++) begin
      rd(4'(a), rdv);
      check($sformatf("reset_rd_%0d", a), rdv, 0);
    end
    cycle();
    check("rdata_idle", bus.AI_READDATA, 0);
    check("reset_enemy_cmd", ENEMY_CMD, 0);
    check("reset_no_update", upd_cnt, 0);

    // Commit path: shadow[2] at address 4+4+2.
    wr(4'd10, 16'hBEEF, 2'b11, 1'b0);
    wr(4'd0, 16'h0002, 2'b01, 1'b0);
    rd(4'd1, rdv);
    check("status_pending", rdv, 16'h0004);
    check("cmd_before_sync", ENEMY_CMD[47:32], 0);
    sync();
    check("cmd_update_hi", CMD_UPDATE, 1);
    rd(4'd1, rdv);
    check("status_after_commit", rdv, 0);
    check("cmd_update_lo", CMD_UPDATE, 0);
    check("enemy_cmd2", ENEMY_CMD[47:32], 16'hBEEF);
    check("update_count1", upd_cnt, 1);
    wr(4'd10, 16'h1234, 2'b01, 1'b0);
    rd(4'd10, rdv);
    check("shadow_byte_merge", rdv, 16'hBE34);
    check("cmd_holds", ENEMY_CMD[47:32], 16'hBEEF);

    // Auto snapshot on frame sync (second sync overall).
    wr(4'd0, 16'h0004, 2'b01, 1'b0);
    PLAYER_LOC = 16'h0A0B;
    ENEMY_LOC  = 64'h4444_3333_1111_0102;
    sync();
    PLAYER_LOC = 16'hFFFF;
    ENEMY_LOC  = '1;
    rd(4'd3, rdv); check("player_snap", rdv, 16'h0A0B);
    rd(4'd4, rdv); check("enemy_snap0", rdv, 16'h0102);
    rd(4'd5, rdv); check("enemy_snap1", rdv, 16'h1111);
    rd(4'd7, rdv); check("enemy_snap3", rdv, 16'h4444);
    rd(4'd1, rdv); check("status_valid", rdv, 16'h0001);
    rd(4'd2, rdv); check("frame_cnt", rdv, 2);

    // Second capture without clearing gives overrun.
    sync();
    rd(4'd1, rdv); check("status_overrun", rdv, 16'h0003);
    rd(4'd3, rdv); check("player_snap2", rdv, 16'hFFFF);
    wr(4'd1, 16'h0003, 2'b01, 1'b0);
    rd(4'd1, rdv); check("status_w1c", rdv, 0);

    // W1C coincident with capture: set wins, no overrun.
    sync();
    wr(4'd1, 16'h0001, 2'b01, 1'b1);
    rd(4'd1, rdv); check("w1c_vs_set", rdv, 16'h0001);
    wr(4'd1, 16'h0003, 2'b01, 1'b0);

    // Manual SNAP together with auto sync: one event, no overrun.
    PLAYER_LOC = 16'h2222;
    wr(4'd0, 16'h0005, 2'b01, 1'b1);
    rd(4'd1, rdv); check("snap_dual_event", rdv, 16'h0001);
    rd(4'd3, rdv); check("player_snap3", rdv, 16'h2222);
    rd(4'd0, rdv); check("ctrl_readback", rdv, 16'h0004);
    wr(4'd1, 16'h0003, 2'b01, 1'b0);
    wr(4'd0, 16'h0000, 2'b01, 1'b0);

    // COMMIT coincident with FRAME_SYNC while idle waits for the next sync.
    wr(4'd8, 16'hCAFE, 2'b11, 1'b0);
    upd_base = upd_cnt;
    wr(4'd0, 16'h0002, 2'b01, 1'b1);
    rd(4'd1, rdv); check("pending_after_coincide", rdv, 16'h0004);
    cycle();
    check("no_update_same_frame", upd_cnt, upd_base);
    check("cmd0_unchanged", ENEMY_CMD[15:0], 0);
    sync();
    cycle();
    check("cmd0_committed", ENEMY_CMD[15:0], 16'hCAFE);
    check("update_next_frame", upd_cnt, upd_base + 1);

    // Shadow write same cycle as commit: active gets old value.
    wr(4'd8, 16'h7777, 2'b11, 1'b0);
    wr(4'd0, 16'h0002, 2'b01, 1'b0);
    wr(4'd0, 16'h0002, 2'b01, 1'b0);
    upd_base = upd_cnt;
    wr(4'd8, 16'h5555, 2'b11, 1'b1);
    cycle();
    check("commit_pre_write", ENEMY_CMD[15:0], 16'h7777);
    check("single_commit", upd_cnt, upd_base + 1);
    rd(4'd8, rdv); check("shadow_post_write", rdv, 16'h5555);

    // Reset while pending: no later update.
    wr(4'd0, 16'h0002, 2'b01, 1'b0);
    RESET = 1'b1; cycle(); RESET = 1'b0;
    upd_base = upd_cnt;
    sync();
    cycle();
    check("no_update_after_reset", upd_cnt, upd_base);
    check("cmd_after_reset", ENEMY_CMD, 0);
    rd(4'd1, rdv); check("status_after_reset", rdv, 0);

`ifdef AI_IRQ_EN
    // Interrupt follows SNAP_VALID one cycle later.
    wr(4'd0, 16'h0009, 2'b01, 1'b0);
    check("irq_low_at_set", AI_IRQ, 0);
    cycle();
    check("irq_high", AI_IRQ, 1);
    rd(4'd0, rdv); check("ctrl_irq_en", rdv, 16'h0008);
    wr(4'd1, 16'h0001, 2'b01, 1'b0);
    check("irq_still_high", AI_IRQ, 1);
    cycle();
    check("irq_low", AI_IRQ, 0);
`else
    wr(4'd0, 16'h0009, 2'b01, 1'b0);
    rd(4'd0, rdv); check("ctrl_irq_en_absent", rdv, 0);
    rd(4'd1, rdv); check("status_manual_snap", rdv, 16'h0001);
`endif

    // FRAME_CNT wrap on the 8-bit instance.
    for (int k = 0; k < 255; k++) begin
      fs2 = 1'b1; cycle(); fs2 = 1'b0;
    end
    bus2.AI_CS = 1'b1; bus2.AI_READ = 1'b1; bus2.AI_ADDR = 3'd2;
    cycle();
    check("frame_cnt_max", bus2.AI_READDATA, 8'hFF);
    bus2.AI_CS = 1'b0; bus2.AI_READ = 1'b0;
    fs2 = 1'b1; cycle(); fs2 = 1'b0;
    bus2.AI_CS = 1'b1; bus2.AI_READ = 1'b1;
    cycle();
    check("frame_cnt_wrap", bus2.AI_READDATA, 8'h00);
    bus2.AI_CS = 1'b0; bus2.AI_READ = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
